// File: rtl/calculator_input_stage.sv
// calculator_input_stage: synchronises and debounces the Enter button and
// turns each clean press into one operand/opcode token on a valid/ready port.
module calculator_input_stage #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WIDTH           = 8
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] NumIn,
    input  logic [1:0]       OpIn,
    input  logic             Enter,
    output logic [WIDTH-1:0] NumOut,
    output logic [1:0]       OpOut,
    output logic             Valid,
    input  logic             Ready,
    output logic             Overrun
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam bit         BYPASS   = (DEBOUNCE_CYCLES == 1);

    logic             enter_s1;
    logic             enter_s2;
    logic [WIDTH-1:0] num_s1;
    logic [WIDTH-1:0] num_s2;
    logic [1:0]       op_s1;
    logic [1:0]       op_s2;
    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cnt;
    logic [7:0]       cnt_nxt;
    logic             press;

    // Operand and opcode share the Enter latency so a token captures the
    // switch settings seen alongside the debounced edge.
    always_ff @(posedge clock) begin
        if (Reset) begin
            enter_s1 <= 1'b0;
            enter_s2 <= 1'b0;
            num_s1   <= '0;
            num_s2   <= '0;
            op_s1    <= '0;
            op_s2    <= '0;
        end else begin
            enter_s1 <= Enter;
            enter_s2 <= enter_s1;
            num_s1   <= NumIn;
            num_s2   <= num_s1;
            op_s1    <= OpIn;
            op_s2    <= op_s1;
        end
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state <= STABLE_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press     = 1'b0;
        unique case (state)
            STABLE_LOW: begin
                if (enter_s2) begin
                    if (BYPASS) begin
                        state_nxt = STABLE_HIGH;
                        press     = 1'b1;
                    end else begin
                        state_nxt = WAIT_HIGH;
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (!enter_s2) begin
                    state_nxt = STABLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = '0;
                    press     = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            STABLE_HIGH: begin
                if (!enter_s2) begin
                    if (BYPASS) begin
                        state_nxt = STABLE_LOW;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = WAIT_LOW;
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            WAIT_LOW: begin
                if (enter_s2) begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
        endcase
    end

    // A press may reuse the slot freed by a same-cycle transfer.
    always_ff @(posedge clock) begin
        if (Reset) begin
            NumOut  <= '0;
            OpOut   <= '0;
            Valid   <= 1'b0;
            Overrun <= 1'b0;
        end else if (press) begin
            if (!Valid || Ready) begin
                NumOut <= num_s2;
                OpOut  <= op_s2;
                Valid  <= 1'b1;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (Ready) begin
            Valid <= 1'b0;
        end
    end

endmodule

// File: doc/calculator_input_stage.md
# calculator_input_stage

Conditions the raw front-panel inputs before they reach the calculator datapath. The raw Enter button is synchronised and debounced, and each clean press becomes exactly one operation token. A token is the operand and opcode captured from the switches, presented downstream through a valid/ready handshake. It sits directly upstream of the calculator core, which executes one operation per accepted token.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive identical synchronised samples required to accept a level change; legal range 1..255.
- WIDTH, default 8: operand width.

Ports:
- clock  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- NumIn  in  WIDTH  raw operand switches.
- OpIn  in  2  raw opcode switches.
- Enter  in  1  raw, bouncy, asynchronous push-button (high = pressed).
- NumOut  out  WIDTH  captured operand; valid while Valid=1.
- OpOut  out  2  captured opcode; valid while Valid=1.
- Valid  out  1  token available.
- Ready  in  1  downstream accepts the token this cycle.
- Overrun  out  1  sticky: a press was dropped because the previous token was not yet taken.

## Operation
- Synchronisers:
  - Enter, NumIn and OpIn each pass through a 2-flop synchroniser: sync1 then sync2.
  - All three paths share the same latency.
- Debounce FSM. It samples sync2 every cycle and uses counter cnt, 8 bits:
  - STABLE_LOW: on sync2=1, set cnt=1 and go to WAIT_HIGH.
  - WAIT_HIGH:
    - sync2=0: go to STABLE_LOW, cnt=0.
    - sync2=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HIGH and fire a press.
    - otherwise: cnt+1.
  - STABLE_HIGH: on sync2=0, set cnt=1 and go to WAIT_LOW.
  - WAIT_LOW:
    - sync2=1: go to STABLE_HIGH.
    - sync2=0 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_LOW, cnt=0.
    - otherwise: cnt+1.
  - DEBOUNCE_CYCLES=1: both WAIT states are bypassed. The first differing sync2 sample changes the state directly, and a press fires on entry to STABLE_HIGH.
- Press: a single-cycle internal pulse on the transition into STABLE_HIGH.
  - Holding the button never produces further presses.
  - Release produces nothing.
- Token register, on press:
  - Valid=0, or Valid=1 with Ready=1: load NumOut and OpOut from the sync2 copies of NumIn and OpIn, and set Valid=1.
  - Valid=1 with Ready=0: discard the press, leave the token unchanged, set Overrun=1.
- Transfer occurs on any cycle with Valid=1 and Ready=1.
  - Without a simultaneous press: Valid goes 0 next cycle. NumOut and OpOut hold their last values.
  - With a simultaneous press: the new token loads and Valid stays 1.
- Ready while Valid=0 has no effect.
- Overrun clears only on Reset.

## Timing
- Reset, synchronous, effective at the first rising edge with Reset=1. Afterwards:
  - Valid=0, Overrun=0, NumOut=0, OpOut=0.
  - Synchronisers and the FSM at 0 / STABLE_LOW, cnt=0.
- Reset mid-debounce or mid-handshake aborts everything, including a pending token, which is lost.
- If Enter is held through reset release, it is debounced and counts as one press.
- Press latency. Let k be the first edge sampling Enter=1, with the button held clean:
  - sync2=1 after edge k+1.
  - Valid=1 after edge k+1+DEBOUNCE_CYCLES.
  - Default DEBOUNCE_CYCLES=4: Valid rises 5 edges after k.
- Captured NumOut and OpOut equal the NumIn and OpIn present at the edge two before the capture edge.
- A bounce shorter than DEBOUNCE_CYCLES synchronised samples, in either direction, causes no state change that is externally visible.
- Minimum press-to-press spacing is DEBOUNCE_CYCLES samples high, then DEBOUNCE_CYCLES samples low, then DEBOUNCE_CYCLES samples high.
- Handshake:
  - NumOut, OpOut and Valid are registered.
  - No combinational path from Ready to any output.
  - Valid never drops without a transfer or Reset.
  - Token contents are stable while Valid=1 and Ready=0.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4, Ready=1:
  - Stimulus: NumIn=8'h2A, OpIn=2'b01; Enter high at edge 10, held 20 cycles.
  - Response: Valid high for exactly one cycle after edge 15, with NumOut=8'h2A and OpOut=2'b01. No second token on release.
- Bounce rejection:
  - Stimulus: Enter toggles 1,1,0,1,0,0 (one value per cycle), then stays 0.
  - Response: Valid never asserts; Overrun=0.
- Bouncy press followed by a stable hold:
  - Stimulus: 3 glitch pulses, then 10 cycles high.
  - Response: exactly one token, issued 4 samples after the last rising glitch.
- Backpressure and overrun, Ready=0:
  - Stimulus: press with NumIn=8'h05; release; press again with NumIn=8'h07.
  - Response: NumOut remains 8'h05, Valid remains 1, Overrun becomes 1.
  - Then Ready=1 for one cycle: Valid=0 next cycle; Overrun stays 1.
- Simultaneous transfer and press:
  - Stimulus: Ready=1 on the exact cycle the second press fires, with NumIn=8'hFF.
  - Response: Valid stays 1, NumOut=8'hFF, Overrun=0.
- Reset mid-operation:
  - Stimulus: assert Reset for one cycle while in WAIT_HIGH, and separately while Valid=1.
  - Response: all outputs 0 next cycle. With Enter still held, a fresh press completes DEBOUNCE_CYCLES+1 edges after Reset deasserts.
